ac_compressor_sequencer: RTL and testbench

Sequences the compressor and fan of the air-conditioner datapath from the operating mode produced by the mode FSM. In AUTO, cooling demand comes from temperature error with hysteresis. In MANUAL, demand is always on and fan speed follows user buttons. The block ramps fan speed one step at a time, pre-ventilates before compressor start, and enforces a minimum compressor off-time (anti-short-cycle lockout). It sits between the mode FSM / temperature sensor and the fan PWM and compressor relay drivers.

---
 rtl/ac_compressor_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ac_compressor_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_compressor_sequencer.sv
// ---------------------------------------------------------------------------
// ac_compressor_sequencer
//
// Sequences the air-conditioner compressor relay and the fan from the
// operating mode chosen by the mode FSM.
//   AUTO   : cooling demand comes from the temperature error, with
//            hysteresis. Fan target is derived from the size of the error.
//   MANUAL : demand is always on. The fan target follows the up/down buttons.
//   IDLE   : no demand (mode 2'b11 is treated the same way).
// The fan ramps one step per RAMP_TICKS ticks. The fan pre-ventilates for
// RAMP_TICKS ticks before the compressor starts. Every compressor stop, and
// every reset, is followed by a MIN_OFF_TICKS lockout (anti-short-cycle).
//
// Parameters
//   TICK_DIV      clk cycles per timing tick
//   RAMP_TICKS    ticks per fan step and length of pre-ventilation
//   MIN_OFF_TICKS ticks of compressor lockout
//   HYST          AUTO hysteresis band in degrees C
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   mode       00 IDLE, 01 AUTO, 10 MANUAL, 11 IDLE
//   temp_cur   measured temperature, unsigned degrees C
//   temp_set   setpoint, unsigned degrees C
//   btn_up     one-cycle debounced pulse, raises the manual fan speed
//   btn_down   one-cycle debounced pulse, lowers the manual fan speed
//   fan_speed  0 off, 1..3 speed (registered)
//   comp_on    compressor relay enable (registered, high only in RUN)
//   lockout    high while in LOCKOUT (registered)
//   state      OFF=0, START=1, RUN=2, STOP=3, LOCKOUT=4 (registered)
// ---------------------------------------------------------------------------
module ac_compressor_sequencer #(
  parameter int TICK_DIV      = 100_000_000,
  parameter int RAMP_TICKS    = 2,
  parameter int MIN_OFF_TICKS = 180,
  parameter int HYST          = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [7:0] temp_cur,
  input  logic [7:0] temp_set,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] fan_speed,
  output logic       comp_on,
  output logic       lockout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_STOP    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

  // Tick divider sizing (guarded so a divide-by-1 still has a 1-bit counter).
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // One phase counter serves both the ramp interval and the lockout period:
  // it is cleared on every state entry, so the two uses never overlap.
  localparam int CNT_MAX = (MIN_OFF_TICKS > RAMP_TICKS) ? MIN_OFF_TICKS : RAMP_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_TICKS - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MIN_OFF_TICKS - 1);

  // Temperature thresholds are evaluated on 9 bits so setpoint + offset
  // cannot wrap around (e.g. temp_set=255 must never look like a small value).
  localparam logic [8:0] HYST9  = 9'(HYST);
  localparam logic [8:0] STEP2  = 9'd3;
  localparam logic [8:0] STEP3  = 9'd6;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic [1:0]       man_speed;
  logic             demand_hold;
  logic             auto_demand;
  logic [1:0]       auto_target;
  logic             demand;
  logic [1:0]       target;

  logic [8:0]       cur9;
  logic [8:0]       set9;

  state_t           state_q;
  logic [CNT_W-1:0] phase_cnt;
  logic [1:0]       fan_q;
  logic             comp_q;
  logic             lockout_q;

  // -------------------------------------------------------------------------
  // Tick generator: free-running 0..TICK_DIV-1, tick high on terminal count.
  // -------------------------------------------------------------------------
  assign tick = (div_cnt == DIV_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Manual fan speed, 1..3, only tracks buttons while MANUAL is selected.
  // Simultaneous up and down cancel out.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      man_speed <= 2'd1;
    end else if (mode == MODE_MANUAL) begin
      if (btn_up && !btn_down && (man_speed != 2'd3)) begin
        man_speed <= man_speed + 2'd1;
      end else if (btn_down && !btn_up && (man_speed != 2'd1)) begin
        man_speed <= man_speed - 2'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // AUTO demand with hysteresis and AUTO fan target.
  // -------------------------------------------------------------------------
  assign cur9 = {1'b0, temp_cur};
  assign set9 = {1'b0, temp_set};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    auto_demand = demand_hold;
    if (cur9 >= set9 + HYST9) begin
      auto_demand = 1'b1;
    end else if (cur9 <= set9) begin
      auto_demand = 1'b0;
    end
  end

  always_comb begin
    auto_target = 2'd1;
    if (cur9 >= set9 + STEP3) begin
      auto_target = 2'd3;
    end else if (cur9 >= set9 + STEP2) begin
      auto_target = 2'd2;
    end
  end

  // Holds the last decision so the band between the two thresholds keeps it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      demand_hold <= 1'b0;
    end else begin
      demand_hold <= auto_demand;
    end
  end

  // Demand and target selected by mode; IDLE and the unused code give no demand.
  always_comb begin
    demand = 1'b0;
    target = 2'd1;
    case (mode)
      MODE_AUTO: begin
        demand = auto_demand;
        target = auto_target;
      end
      MODE_MANUAL: begin
        demand = 1'b1;
        target = man_speed;
      end
      default: begin
        demand = 1'b0;
        target = 2'd1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered and updated on the same edge
  // as the state change that implies them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LOCKOUT;
      phase_cnt <= '0;
      fan_q     <= 2'd0;
      comp_q    <= 1'b0;
      lockout_q <= 1'b1;
    end else begin
      case (state_q)
        // Full off-time, demand ignored.
        ST_LOCKOUT: begin
          if (tick) begin
            if (phase_cnt == LOCK_LAST) begin
              state_q   <= ST_OFF;
              lockout_q <= 1'b0;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end

        ST_OFF: begin
          if (demand) begin
            state_q   <= ST_START;
            fan_q     <= 2'd1;
            phase_cnt <= '0;
          end
        end

        // Pre-ventilation. Losing demand here returns straight to OFF: the
        // compressor never ran, so no lockout is needed.
        ST_START: begin
          if (!demand) begin
            state_q   <= ST_OFF;
            fan_q     <= 2'd0;
            phase_cnt <= '0;
          end else if (tick) begin
            if (phase_cnt == RAMP_LAST) begin
              state_q   <= ST_RUN;
              comp_q    <= 1'b1;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end

        // Compressor on; fan walks toward the target one step per interval.
        // The interval restarts whenever the fan is already on target, so a
        // new target always waits a full interval before the first step.
        ST_RUN: begin
          if (!demand) begin
            state_q   <= ST_STOP;
            comp_q    <= 1'b0;
            phase_cnt <= '0;
          end else if (fan_q == target) begin
            phase_cnt <= '0;
          end else if (tick) begin
            if (phase_cnt == RAMP_LAST) begin
              fan_q     <= (target > fan_q) ? fan_q + 2'd1 : fan_q - 2'd1;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end

        // Compressor off; fan ramps down, then lockout starts fresh.
        ST_STOP: begin
          if (tick) begin
            if (phase_cnt == RAMP_LAST) begin
              fan_q     <= fan_q - 2'd1;
              phase_cnt <= '0;
              if (fan_q == 2'd1) begin
                state_q   <= ST_LOCKOUT;
                lockout_q <= 1'b1;
              end
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
        end

        // Unreachable encodings recover through a full lockout.
        default: begin
          state_q   <= ST_LOCKOUT;
          phase_cnt <= '0;
          fan_q     <= 2'd0;
          comp_q    <= 1'b0;
          lockout_q <= 1'b1;
        end
      endcase
    end
  end

  assign fan_speed = fan_q;
  assign comp_on   = comp_q;
  assign lockout   = lockout_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for ac_compressor_sequencer.
// A behavioural model (phase + elapsed ticks, plain integers) predicts the
// outputs after every clock edge and queues them; a monitor pops and compares
// on the falling edge. Directed sequences walk the main scenarios, then a
// randomized phase exercises mode/temperature/button mixes.
// ---------------------------------------------------------------------------
module tb_ac_compressor_sequencer;

  localparam int TICK_DIV      = 4;
  localparam int RAMP_TICKS    = 2;
  localparam int MIN_OFF_TICKS = 3;
  localparam int HYST          = 2;

  localparam int S_OFF   = 0;
  localparam int S_START = 1;
  localparam int S_RUN   = 2;
  localparam int S_STOP  = 3;
  localparam int S_LOCK  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] temp_cur;
  logic [7:0] temp_set;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] fan_speed;
  logic       comp_on;
  logic       lockout;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  ac_compressor_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .RAMP_TICKS    (RAMP_TICKS),
    .MIN_OFF_TICKS (MIN_OFF_TICKS),
    .HYST          (HYST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .temp_cur  (temp_cur),
    .temp_set  (temp_set),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .fan_speed (fan_speed),
    .comp_on   (comp_on),
    .lockout   (lockout),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct {
    int div;    // cycles since last tick
    int phase;  // S_* code
    int el;     // ticks elapsed in the current interval
    int fan;
    int man;
    int hold;   // remembered AUTO demand
  } model_t;

  localparam model_t MODEL_RESET = '{div: 0, phase: S_LOCK, el: 0, fan: 0, man: 1, hold: 0};

  model_t m = MODEL_RESET;
  logic [6:0] exp_q[$];

  function automatic model_t model_next(model_t s, int md, int cur, int set, bit up, bit dn);
    model_t n = s;
    bit tk = (s.div == TICK_DIV - 1);
    int auto_dem;
    int dem;
    int tgt;
    int diff = cur - set;
    n.div = (s.div + 1) % TICK_DIV;

    if (cur >= set + HYST)  auto_dem = 1;
    else if (cur <= set)    auto_dem = 0;
    else                    auto_dem = s.hold;
    n.hold = auto_dem;

    if (md == 1) begin
      dem = auto_dem;
      tgt = (diff >= 6) ? 3 : (diff >= 3) ? 2 : 1;
    end else if (md == 2) begin
      dem = 1;
      tgt = s.man;
    end else begin
      dem = 0;
      tgt = 1;
    end

    if (md == 2 && up && !dn) n.man = (s.man < 3) ? s.man + 1 : 3;
    if (md == 2 && dn && !up) n.man = (s.man > 1) ? s.man - 1 : 1;

    case (s.phase)
      S_LOCK: if (tk) begin
        n.el = s.el + 1;
        if (n.el == MIN_OFF_TICKS) begin n.phase = S_OFF; n.el = 0; end
      end
      S_OFF: if (dem == 1) begin n.phase = S_START; n.fan = 1; n.el = 0; end
      S_START: begin
        if (dem == 0) begin n.phase = S_OFF; n.fan = 0; n.el = 0; end
        else if (tk) begin
          n.el = s.el + 1;
          if (n.el == RAMP_TICKS) begin n.phase = S_RUN; n.el = 0; end
        end
      end
      S_RUN: begin
        if (dem == 0) begin n.phase = S_STOP; n.el = 0; end
        else if (s.fan == tgt) n.el = 0;
        else if (tk) begin
          n.el = s.el + 1;
          if (n.el == RAMP_TICKS) begin
            n.fan = s.fan + ((tgt > s.fan) ? 1 : -1);
            n.el  = 0;
          end
        end
      end
      S_STOP: if (tk) begin
        n.el = s.el + 1;
        if (n.el == RAMP_TICKS) begin
          n.fan = s.fan - 1;
          n.el  = 0;
          if (n.fan == 0) n.phase = S_LOCK;
        end
      end
      default: n = MODEL_RESET;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] expected_of(model_t s);
    return {3'(s.phase), 2'(s.fan), (s.phase == S_RUN), (s.phase == S_LOCK)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m <= MODEL_RESET;
      exp_q.push_back(expected_of(MODEL_RESET));
    end else begin
      m <= model_next(m, int'(mode), int'(temp_cur), int'(temp_set), btn_up, btn_down);
      exp_q.push_back(expected_of(
        model_next(m, int'(mode), int'(temp_cur), int'(temp_set), btn_up, btn_down)));
    end
  end

  // Monitor: compares every post-edge output set against the model.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("outputs{state,fan,comp,lockout}", {25'd0, state, fan_speed, comp_on, lockout},
            {25'd0, exp_q.pop_front()});
    end
  end

  // -------------------------------------------------------------------------
  // Bounded waits for directed sequences (called at falling edges).
  // -------------------------------------------------------------------------
  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
    int k = 0;
    while (state !== s && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, {29'd0, state}, {29'd0, s});
  endtask

  task automatic wait_fan(input logic [1:0] f, input int max_cyc, input string name);
    int k = 0;
    while (fan_speed !== f && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(name, {30'd0, fan_speed}, {30'd0, f});
  endtask

  task automatic pulse(input bit up, input bit dn);
    btn_up   = up;
    btn_down = dn;
    @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset    = 1'b1;
    mode     = 2'b00;
    temp_set = 8'd24;
    temp_cur = 8'd20;
    btn_up   = 1'b0;
    btn_down = 1'b0;

    // Reset state and power-on lockout (3 ticks = 12 cycles).
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, state}, 32'd4);
    check("reset_lockout", {31'd0, lockout}, 32'd1);
    check("reset_fan", {30'd0, fan_speed}, 32'd0);
    check("reset_comp", {31'd0, comp_on}, 32'd0);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    check("lockout_still_at_11", {29'd0, state}, 32'd4);
    @(negedge clk);
    check("off_after_12", {29'd0, state}, 32'd0);
    check("lockout_low_after_12", {31'd0, lockout}, 32'd0);

    // AUTO start and ramp up.
    mode     = 2'b01;
    temp_cur = 8'd26;
    @(negedge clk);
    check("auto_start_state", {29'd0, state}, 32'd1);
    check("auto_start_fan", {30'd0, fan_speed}, 32'd1);
    wait_state(3'd2, 12, "auto_reach_run");
    check("run_comp", {31'd0, comp_on}, 32'd1);
    repeat (12) @(negedge clk);
    check("run_fan_stays_1", {30'd0, fan_speed}, 32'd1);
    temp_cur = 8'd31;
    wait_fan(2'd2, 9, "ramp_fan_2");
    wait_fan(2'd3, 9, "ramp_fan_3");

    // Hysteresis in RUN, then stop sequence from fan 3.
    temp_cur = 8'd25;
    repeat (4) @(negedge clk);
    check("hyst_run_holds", {29'd0, state}, 32'd2);
    temp_cur = 8'd24;
    @(negedge clk);
    check("stop_state", {29'd0, state}, 32'd3);
    check("stop_comp_off", {31'd0, comp_on}, 32'd0);
    wait_fan(2'd2, 9, "stop_fan_2");
    wait_fan(2'd1, 9, "stop_fan_1");
    wait_fan(2'd0, 9, "stop_fan_0");
    check("stop_to_lockout", {29'd0, state}, 32'd4);
    temp_cur = 8'd30;
    repeat (8) @(negedge clk);
    check("lockout_ignores_demand", {29'd0, state}, 32'd4);
    wait_state(3'd0, 8, "lockout_to_off");
    @(negedge clk);
    check("off_then_start", {29'd0, state}, 32'd1);

    // Demand loss in START, then hysteresis in OFF.
    temp_cur = 8'd24;
    @(negedge clk);
    check("start_abort_auto", {29'd0, state}, 32'd0);
    temp_cur = 8'd25;
    repeat (12) @(negedge clk);
    check("hyst_off_holds", {29'd0, state}, 32'd0);

    // MANUAL: START abort via IDLE, then buttons.
    mode = 2'b10;
    @(negedge clk);
    check("manual_start", {29'd0, state}, 32'd1);
    mode = 2'b00;
    @(negedge clk);
    check("idle_abort_state", {29'd0, state}, 32'd0);
    check("idle_abort_comp", {31'd0, comp_on}, 32'd0);
    check("idle_abort_no_lockout", {31'd0, lockout}, 32'd0);
    mode = 2'b10;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    wait_state(3'd2, 12, "manual_run");
    wait_fan(2'd3, 20, "manual_fan_3");
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
    wait_fan(2'd1, 20, "manual_fan_1");
    pulse(1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("both_buttons_no_change", {30'd0, fan_speed}, 32'd1);
    pulse(1'b1, 1'b0);
    wait_fan(2'd2, 12, "manual_fan_2");

    // MANUAL -> AUTO in RUN only retargets.
    mode     = 2'b01;
    temp_cur = 8'd30;
    @(negedge clk);
    check("retarget_keeps_run", {29'd0, state}, 32'd2);
    check("retarget_keeps_comp", {31'd0, comp_on}, 32'd1);
    wait_fan(2'd3, 12, "retarget_fan_3");

    // Reset mid-RUN.
    #1 reset = 1'b1;
    #1;
    check("midrun_reset_comp", {31'd0, comp_on}, 32'd0);
    check("midrun_reset_state", {29'd0, state}, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    check("midrun_lockout_full", {29'd0, state}, 32'd4);
    @(negedge clk);
    check("midrun_off", {29'd0, state}, 32'd0);
    @(negedge clk);
    check("midrun_restart", {29'd0, state}, 32'd1);

    // Overflow boundary.
    temp_set = 8'd250;
    temp_cur = 8'd252;
    wait_state(3'd2, 12, "ovf_run");
    repeat (8) @(negedge clk);
    check("ovf_target_1", {30'd0, fan_speed}, 32'd1);
    temp_cur = 8'd255;
    wait_fan(2'd2, 9, "ovf_target_2");
    temp_set = 8'd255;
    temp_cur = 8'd0;
    @(negedge clk);
    check("ovf_no_wrap_stop", {29'd0, state}, 32'd3);
    wait_state(3'd4, 20, "ovf_lockout");
    wait_state(3'd0, 16, "ovf_off");
    temp_set = 8'd254;
    repeat (8) @(negedge clk);
    check("ovf_no_false_start", {29'd0, state}, 32'd0);

    // Randomized mix.
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      mode     = 2'($urandom_range(0, 3));
      temp_set = 8'($urandom_range(15, 35));
      temp_cur = 8'(int'(temp_set) + int'($urandom_range(0, 12)) - 4);
      if ($urandom_range(0, 9) == 0) begin
        temp_set = 8'($urandom);
        temp_cur = 8'($urandom);
      end
      len = int'($urandom_range(1, 24));
      for (int c = 0; c < len; c++) begin
        btn_up   = ($urandom_range(0, 5) == 0);
        btn_down = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
